// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_unit
// Purpose  : HI/LO register file with mult/multu, mthi/mtlo and a 32-step
//            restoring divider; provides the same-cycle write bypass to ID.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hilo_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        hold,
  output logic        stallreq,
  output logic [1:0]  hilo_we,
  output logic [31:0] hi_i,
  output logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_rem, r_quot, r_dvs, r_src1, r_hi, r_lo;
  logic           r_neg_q, r_neg_r, r_dvz;
  logic           w_start;

  logic w_div, w_divu, w_mult, w_multu, w_mthi, w_mtlo;
  assign {w_div, w_divu, w_mult, w_multu, w_mthi, w_mtlo} = hilo_op;

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  assign w_prod_s = $signed(src1) * $signed(src2);
  assign w_prod_u = {32'd0, src1} * {32'd0, src2};

  logic [31:0] w_a_mag, w_b_mag;
  assign w_a_mag = (w_div && src1[31]) ? -src1 : src1;
  assign w_b_mag = (w_div && src2[31]) ? -src2 : src2;

  // One restoring step: the shifted remainder needs 33 bits before the trial subtract.
  logic [32:0] w_shift, w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_nxt;
  assign w_shift   = {r_rem, r_quot[31]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_diff[32];
  assign w_rem_nxt = w_qbit ? w_diff[31:0] : w_shift[31:0];

  logic [31:0] w_quot_fix, w_rem_fix;
  assign w_quot_fix = r_dvz ? 32'hFFFF_FFFF : (r_neg_q ? -r_quot : r_quot);
  assign w_rem_fix  = r_dvz ? r_src1 : (r_neg_r ? -r_rem : r_rem);

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    stallreq = 1'b0;
    hilo_we  = 2'b00;
    hi_i     = 32'd0;
    lo_i     = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (!hold) begin
          if (w_div || w_divu) begin
            stallreq = 1'b1;
            w_start  = 1'b1;
            w_next   = S_BUSY;
          end else if (w_mult) begin
            hilo_we      = 2'b11;
            {hi_i, lo_i} = w_prod_s;
          end else if (w_multu) begin
            hilo_we      = 2'b11;
            {hi_i, lo_i} = w_prod_u;
          end else if (w_mthi) begin
            hilo_we = 2'b10;
            hi_i    = src1;
          end else if (w_mtlo) begin
            hilo_we = 2'b01;
            lo_i    = src1;
          end
        end
      end
      S_BUSY: begin
        stallreq = 1'b1;
        if (r_cnt == CW'(DIV_CYCLES - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        if (!hold) begin
          hilo_we = 2'b11;
          hi_i    = w_rem_fix;
          lo_i    = w_quot_fix;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      w_next   = S_IDLE;
      w_start  = 1'b0;
      stallreq = 1'b0;
      hilo_we  = 2'b00;
      hi_i     = 32'd0;
      lo_i     = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= 32'd0;
      r_quot  <= 32'd0;
      r_dvs   <= 32'd0;
      r_src1  <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dvz   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt   <= '0;
        r_rem   <= 32'd0;
        r_quot  <= w_a_mag;
        r_dvs   <= w_b_mag;
        r_src1  <= src1;
        r_neg_q <= w_div & (src1[31] ^ src2[31]);
        r_neg_r <= w_div & src1[31];
        r_dvz   <= (src2 == 32'd0);
      end else if (r_state == S_BUSY) begin
        r_cnt  <= r_cnt + 1'b1;
        r_rem  <= w_rem_nxt;
        r_quot <= {r_quot[30:0], w_qbit};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (!hold) begin
      if (hilo_we[1]) r_hi <= hi_i;
      if (hilo_we[0]) r_lo <= lo_i;
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_unit
// Purpose  : Directed self-checking bench for hilo_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hilo_op;
  logic [31:0] src1, src2;
  logic        hold;
  logic        stallreq;
  logic [1:0]  hilo_we;
  logic [31:0] hi_i, lo_i, hi_o, lo_o;

  localparam logic [5:0] OP_DIV   = 6'b100000;
  localparam logic [5:0] OP_DIVU  = 6'b010000;
  localparam logic [5:0] OP_MULT  = 6'b001000;
  localparam logic [5:0] OP_MULTU = 6'b000100;
  localparam logic [5:0] OP_MTHI  = 6'b000010;
  localparam logic [5:0] OP_MTLO  = 6'b000001;

  int n_checks = 0;
  int n_pass   = 0;

  hilo_unit #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .hilo_op(hilo_op), .src1(src1), .src2(src2),
    .hold(hold), .stallreq(stallreq), .hilo_we(hilo_we),
    .hi_i(hi_i), .lo_i(lo_i), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  n_stall = 0;
    bit  done    = 0;
    hilo_op = op; src1 = a; src2 = b;
    for (int i = 0; i < 50 && !done; i++) begin
      #4;
      if (stallreq) n_stall++;
      else if (hilo_we == 2'b11) begin
        done = 1;
        check({tag, "_done_hi_i"}, 64'(hi_i), 64'(exp_hi));
        check({tag, "_done_lo_i"}, 64'(lo_i), 64'(exp_lo));
      end
      next_cycle();
    end
    check({tag, "_completed"}, 64'(done), 64'd1);
    check({tag, "_stall_cycles"}, 64'(n_stall), 64'd33);
    hilo_op = 6'd0;
    #4;
    check({tag, "_no_rerun"}, 64'({stallreq, hilo_we}), 64'd0);
    check({tag, "_hilo_o"}, {hi_o, lo_o}, {exp_hi, exp_lo});
    next_cycle();
  endtask

  initial begin
    int bad;
    rst = 1'b1; hilo_op = 6'd0; src1 = 32'd0; src2 = 32'd0; hold = 1'b0;
    next_cycle();
    next_cycle();
    #4;
    check("reset_hilo_o", {hi_o, lo_o}, 64'd0);
    check("reset_strobes", 64'({stallreq, hilo_we}), 64'd0);
    check("reset_bypass", {hi_i, lo_i}, 64'd0);
    next_cycle();
    rst = 1'b0;

    // mthi then mtlo
    hilo_op = OP_MTHI; src1 = 32'h1234_5678;
    #4;
    check("mthi_we", 64'(hilo_we), 64'd2);
    check("mthi_hi_i", 64'(hi_i), 64'h1234_5678);
    next_cycle();
    hilo_op = OP_MTLO; src1 = 32'h9ABC_DEF0;
    #4;
    check("mtlo_we", 64'(hilo_we), 64'd1);
    check("mtlo_lo_i", 64'(lo_i), 64'h9ABC_DEF0);
    next_cycle();
    hilo_op = 6'd0;
    #4;
    check("mtx_hilo_o", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);
    check("noop_we", 64'(hilo_we), 64'd0);
    next_cycle();

    // mult / multu
    hilo_op = OP_MULT; src1 = 32'hFFFF_FFFE; src2 = 32'd3;
    #4;
    check("mult_we", 64'(hilo_we), 64'd3);
    check("mult_bypass", {hi_i, lo_i}, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mult_nostall", 64'(stallreq), 64'd0);
    next_cycle();
    hilo_op = OP_MULTU;
    #4;
    check("multu_bypass", {hi_i, lo_i}, 64'h0000_0002_FFFF_FFFA);
    check("multu_nostall", 64'(stallreq), 64'd0);
    next_cycle();
    hilo_op = 6'd0;
    #4;
    check("multu_hilo_o", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
    next_cycle();

    // divides
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_div("divu_by0", OP_DIVU, 32'd12345, 32'd0, 32'd12345, 32'hFFFF_FFFF);
    run_div("div_by0", OP_DIV, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);

    // hold through BUSY and DONE: 200/9 = 22 r 2
    hilo_op = OP_DIVU; src1 = 32'd200; src2 = 32'd9;
    for (int i = 0; i < 5; i++) next_cycle();
    hold = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      #4;
      if (hilo_we != 2'b00) bad++;
      next_cycle();
    end
    check("hold_no_we", 64'(bad), 64'd0);
    check("hold_hilo_o", {hi_o, lo_o}, {32'hFFFF_FF00, 32'hFFFF_FFFF});
    hold = 1'b0;
    #4;
    check("hold_release_we", 64'(hilo_we), 64'd3);
    check("hold_release_bypass", {hi_i, lo_i}, {32'd2, 32'd22});
    next_cycle();
    hilo_op = 6'd0;
    #4;
    check("hold_release_hilo_o", {hi_o, lo_o}, {32'd2, 32'd22});
    check("hold_release_idle", 64'({stallreq, hilo_we}), 64'd0);
    next_cycle();

    // mult under hold must not commit
    hold = 1'b1; hilo_op = OP_MULT; src1 = 32'd5; src2 = 32'd6;
    #4;
    check("mult_hold_we", 64'(hilo_we), 64'd0);
    next_cycle();
    hold = 1'b0; hilo_op = 6'd0;
    #4;
    check("mult_hold_hilo_o", {hi_o, lo_o}, {32'd2, 32'd22});
    next_cycle();

    // reset around iteration 10 aborts the divide
    hilo_op = OP_DIVU; src1 = 32'd1000; src2 = 32'd3;
    for (int i = 0; i < 11; i++) next_cycle();
    #4;
    check("pre_rst_stall", 64'(stallreq), 64'd1);
    next_cycle();
    rst = 1'b1; hilo_op = 6'd0;
    next_cycle();
    rst = 1'b0;
    #4;
    check("rst_abort_stall", 64'(stallreq), 64'd0);
    check("rst_abort_hilo_o", {hi_o, lo_o}, 64'd0);
    check("rst_abort_we", 64'(hilo_we), 64'd0);
    next_cycle();
    hilo_op = OP_MULTU; src1 = 32'd7; src2 = 32'd6;
    #4;
    check("post_rst_idle_mult", {hi_i, lo_i}, 64'd42);
    next_cycle();
    hilo_op = 6'd0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
